bus_mux_reg_n: RTL and testbench

- Parametrised, registered N-to-1 bus multiplexer for the datapath. Replaces the fixed 13-source, 16-bit combinational bus mux.
- Selection requests arrive on a valid/ready handshake. The selected source word is captured into a single output register, which is presented downstream with its own valid/ready handshake.
- Adds behaviour the fixed mux lacks: a defined zero result for out-of-range selects, backpressure, and a transfer counter.

---
 rtl/bus_mux_defs.sv | 22 ++
 rtl/bus_mux_sel_n.sv | 34 +++
 rtl/bus_mux_reg_n.sv | 92 +++++++++
 tb/tb_bus_mux_reg_n.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/bus_mux_defs.sv
// Shared defaults and helpers for the registered bus multiplexer family.
package bus_mux_defs;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NSRC  = 13;
   localparam int DEF_SELW  = 4;
   localparam int DEF_CNTW  = 16;

   // Minimum index width able to address n sources (at least 1 bit).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Low bit of source k inside the flattened input bus.
   function automatic int src_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/bus_mux_sel_n.sv
// Combinational N-to-1 slice selector; out-of-range selects yield zero data.
module bus_mux_sel_n
   import bus_mux_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NSRC  = DEF_NSRC,
   parameter int SELW  = DEF_SELW
) (
   input  logic [NSRC*WIDTH-1:0] in_bus,
   input  logic [SELW-1:0]       sel,
   output logic [WIDTH-1:0]      data,
   output logic                  in_range
);

   logic [WIDTH-1:0] slices [NSRC];

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_slice
      localparam int LO = src_lo(gi, WIDTH);
      assign slices[gi] = in_bus[LO +: WIDTH];
   end

   // Compare-and-pick keeps unused select codes from indexing past the array.
   always_comb begin
      data     = '0;
      in_range = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (sel == SELW'(k)) begin
            data     = slices[k];
            in_range = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_mux_reg_n.sv
// Registered N-to-1 bus mux with valid/ready on both sides and a transfer counter.
// Optional err output for out-of-range selects is enabled by BUS_MUX_ERR_EN.
module bus_mux_reg_n
   import bus_mux_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NSRC  = DEF_NSRC,
   parameter int SELW  = clog2(NSRC),
   parameter int CNTW  = DEF_CNTW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NSRC*WIDTH-1:0] in_bus,
   input  logic [SELW-1:0]       sel,
   input  logic                  sel_valid,
   output logic                  sel_ready,
   output logic [WIDTH-1:0]      out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNTW-1:0]       xfer_cnt
`ifdef BUS_MUX_ERR_EN
   ,
   output logic                  err
`endif
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_in_range;
   logic             accept;

   logic [WIDTH-1:0] out_q,   out_d;
   logic             valid_q, valid_d;
   logic [CNTW-1:0]  cnt_q,   cnt_d;

   bus_mux_sel_n #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC),
      .SELW  (SELW)
   ) u_sel (
      .in_bus   (in_bus),
      .sel      (sel),
      .data     (sel_data),
      .in_range (sel_in_range)
   );

   // A full register can still take a new word when it is drained on the same edge.
   assign sel_ready = !valid_q || out_ready;
   assign accept    = sel_valid && sel_ready;

   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (accept) begin
         out_d   = sel_data;
         valid_d = 1'b1;
         cnt_d   = cnt_q + 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign xfer_cnt  = cnt_q;

`ifdef BUS_MUX_ERR_EN
   logic err_q, err_d;

   assign err_d = accept && !sel_in_range;

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_bus_mux_reg_n.sv
// Scoreboard bench for bus_mux_reg_n, including a CNTW=4 instance for counter wrap.
module tb_bus_mux_reg_n;

   localparam int W = 16;
   localparam int N = 13;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_bus;
   logic [3:0]     sel;
   logic           sel_valid;
   logic           sel_ready, sel_ready4;
   logic [W-1:0]   out, out4;
   logic           out_valid, out_valid4;
   logic           out_ready;
   logic [15:0]    xfer_cnt;
   logic [3:0]     xfer_cnt4;
`ifdef BUS_MUX_ERR_EN
   logic           err, err4;
`endif

   logic [W-1:0] src [N];
   logic [W-1:0] sb [$];

   logic         m_valid;
   logic [W-1:0] m_out;
   logic [15:0]  m_cnt;
   logic         m_err;
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_bus = '0;
      for (int k = 0; k < N; k++) in_bus[k*W +: W] = src[k];
   end

   bus_mux_reg_n dut (
      .clk (clk), .rst (rst), .in_bus (in_bus), .sel (sel),
      .sel_valid (sel_valid), .sel_ready (sel_ready),
      .out (out), .out_valid (out_valid), .out_ready (out_ready),
      .xfer_cnt (xfer_cnt)
`ifdef BUS_MUX_ERR_EN
      , .err (err)
`endif
   );

   bus_mux_reg_n #(.CNTW(4)) dut4 (
      .clk (clk), .rst (rst), .in_bus (in_bus), .sel (sel),
      .sel_valid (sel_valid), .sel_ready (sel_ready4),
      .out (out4), .out_valid (out_valid4), .out_ready (out_ready),
      .xfer_cnt (xfer_cnt4)
`ifdef BUS_MUX_ERR_EN
      , .err (err4)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
   endtask

   // One clock of stimulus; expected word is queued at drive time, popped after the edge.
   task automatic step(input logic r, input logic sv, input logic [3:0] s, input logic ordy);
      logic acc;
      @(negedge clk);
      rst = r; sel_valid = sv; sel = s; out_ready = ordy;
      #1;
      check("sel_ready", {31'b0, sel_ready}, {31'b0, (!m_valid || ordy)});
      acc = !r && sv && (!m_valid || ordy);
      if (acc) sb.push_back((s < 4'(N)) ? src[int'(s)] : 16'h0000);
      @(posedge clk);
      #1;
      if (r) begin
         m_valid = 1'b0; m_out = '0; m_cnt = '0; m_err = 1'b0; sb.delete();
      end else if (acc) begin
         m_valid = 1'b1; m_out = sb.pop_front(); m_cnt = m_cnt + 16'd1;
         m_err = (s >= 4'(N));
      end else begin
         if (m_valid && ordy) m_valid = 1'b0;
         m_err = 1'b0;
      end
      $display("t=%0t rst=%b sv=%b sel=%0d ordy=%b -> out=%h ov=%b cnt=%0d",
               $time, r, sv, s, ordy, out, out_valid, xfer_cnt);
      check("out",       {16'b0, out},         {16'b0, m_out});
      check("out_valid", {31'b0, out_valid},   {31'b0, m_valid});
      check("xfer_cnt",  {16'b0, xfer_cnt},    {16'b0, m_cnt});
      check("out4",      {16'b0, out4},        {16'b0, m_out});
      check("xfer_cnt4", {28'b0, xfer_cnt4},   {28'b0, m_cnt[3:0]});
`ifdef BUS_MUX_ERR_EN
      check("err",       {31'b0, err},         {31'b0, m_err});
`endif
   endtask

   initial begin
      for (int k = 0; k < N; k++) src[k] = 16'h1000 + 16'(k);
      rst = 1'b1; sel = '0; sel_valid = 1'b0; out_ready = 1'b0;
      m_valid = 1'b0; m_out = '0; m_cnt = '0; m_err = 1'b0;

      // Reset, then a single select
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(0, 1, 5, 1);
      check("basic_out", {16'b0, out}, 32'h1005);
      step(0, 0, 0, 1);

      // Streaming one transfer per cycle
      for (int k = 0; k < N; k++) step(0, 1, 4'(k), 1);
      check("stream_cnt", {16'b0, xfer_cnt}, 32'd14);
      step(0, 0, 0, 1);

      // Backpressure with source changing under a held word
      step(0, 1, 3, 1);
      src[3] = 16'hBEEF;
      for (int k = 0; k < 4; k++) step(0, 1, 7, 0);
      check("bp_hold", {16'b0, out}, 32'h1003);
      step(0, 1, 7, 1);
      check("bp_load", {16'b0, out}, 32'h1007);
      src[3] = 16'h1003;
      step(0, 0, 0, 1);

      // Out-of-range selects, single then back-to-back
      step(0, 1, 14, 1);
      step(0, 0, 0, 1);
      step(0, 1, 15, 1);
      step(0, 1, 13, 1);
      step(0, 1, 2, 1);
      step(0, 0, 0, 1);

      // Reset while full and stalled with a select pending
      step(0, 1, 1, 1);
      step(1, 1, 4, 0);
      check("rst_mid_cnt", {16'b0, xfer_cnt}, 32'd0);

      // Counter wrap on the narrow instance: 17 accepts -> 1
      for (int k = 0; k < 17; k++) step(0, 1, 4'(k % 16), 1);
      check("wrap_cnt4", {28'b0, xfer_cnt4}, 32'd1);

      // Random traffic
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 3) == 0) src[$urandom_range(0, N-1)] = 16'($urandom);
         step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
